uart_transmisor: RTL and testbench

UART_TRANSMISOR -- requirements
Module: uart_transmisor

---
 rtl/uart_transmisor_pkg.sv | 28 ++
 rtl/uart_transmisor_generador_baudios.sv | 34 +++
 rtl/uart_transmisor.sv | 176 +++++++++++++++++
 tb/tb_uart_transmisor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_transmisor_pkg.sv
// Shared UART transmitter definitions: FSM encoding, line levels and frame sizes.
// Frame length follows UART_TX_PARITY_EN (11 bits with even parity, 10 without).
package uart_transmisor_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic TX_IDLE      = 1'b1;
    localparam logic TX_START_BIT = 1'b0;

    localparam int FRAME_BITS_NO_PARITY = 10;
    localparam int FRAME_BITS_PARITY    = 11;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
    localparam int FRAME_BITS = FRAME_BITS_NO_PARITY;
`endif

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_transmisor_generador_baudios.sv
// Bit-period timer: tick is high in the last cycle of every CLKS_PER_BIT-cycle window.
// restart zeroes the count so the next window starts on the following cycle.
module generador_baudios #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmisor.sv
// FIFO-buffered 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined); first start
// bit one cycle after a push into an empty FIFO; pushes while full are dropped and flag overflow.
module uart_transmisor
    import uart_transmisor_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       ready,
    output logic       is_transmitting,
    output logic       sent,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty;
    logic          push, pop;

    tx_state_e     state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic [2:0]    idx_q, idx_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          sent_q, sent_d;
    logic          ovf_q, ovf_d;

    logic          baud_restart, baud_tick;

    generador_baudios #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .restart(baud_restart),
        .tick   (baud_tick)
    );

    // Full when the wrap bits differ and the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost.
    assign push  = tx_start && !fifo_full;
    assign ovf_d = ovf_q || (tx_start && fifo_full);

    assign wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= tx_byte;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        idx_d        = idx_q;
        pop          = 1'b0;
        baud_restart = 1'b0;
        sent_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    data_d       = fifo_head;
                    idx_d        = 3'd0;
                    state_d      = START;
                    baud_restart = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d      = DATA;
                    idx_d        = 3'd0;
                    baud_restart = 1'b1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    idx_d        = idx_q + 3'd1;
                    baud_restart = 1'b1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d      = STOP;
                    baud_restart = 1'b1;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    sent_d       = 1'b1;
                    baud_restart = 1'b1;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_head;
                        idx_d   = 3'd0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so tx comes straight from a flop.
    always_comb begin
        tx_d = TX_IDLE;
        case (state_d)
            START:   tx_d = TX_START_BIT;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = even_parity(data_d);
            default: tx_d = TX_IDLE;
        endcase
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            tx_q     <= TX_IDLE;
            busy_q   <= 1'b0;
            sent_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            sent_q   <= sent_d;
            ovf_q    <= ovf_d;
        end
    end

    assign tx              = tx_q;
    assign ready           = !fifo_full;
    assign is_transmitting = busy_q;
    assign sent            = sent_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_uart_transmisor.sv
// Directed bench for uart_transmisor at 4 clocks/bit with a 4-entry FIFO.
module tb_uart_transmisor;
    import uart_transmisor_pkg::*;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_CYC = CPB * FRAME_BITS;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx, ready, is_transmitting, sent, overflow;

    int n_vec = 0;
    int n_err = 0;

    uart_transmisor #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tx_start       (tx_start),
        .tx_byte        (tx_byte),
        .tx             (tx),
        .ready          (ready),
        .is_transmitting(is_transmitting),
        .sent           (sent),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Serial line decoder: samples each bit in the middle of its window.
    logic [7:0] rx_q [$];
    bit         rx_act = 1'b0;
    int         rx_ph  = 0;
    logic [7:0] rx_sh  = '0;
    int         sent_cnt = 0;

    always @(negedge clk) begin
        if (sent === 1'b1) sent_cnt++;
        if (reset) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_ph  = 1;
                rx_sh  = '0;
            end
        end else begin
            if ((rx_ph % CPB) == 2) begin
                if (rx_ph / CPB >= 1 && rx_ph / CPB <= 8)
                    rx_sh[3'((rx_ph / CPB) - 1)] = tx;
            end
            rx_ph++;
            if (rx_ph == FRAME_CYC) begin
                rx_act = 1'b0;
                rx_q.push_back(rx_sh);
            end
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Drive a one-cycle push; back-to-back calls hold tx_start high continuously.
    task automatic push(input logic [7:0] b);
        tx_start = 1'b1;
        tx_byte  = b;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (is_transmitting && n < limit) begin
            @(negedge clk);
            n++;
        end
        check1("idle within bound", is_transmitting, 1'b0);
    endtask

    // Called at the first start-bit cycle; seq is start..stop, first bit in the MSB.
    task automatic expect_frame(input logic [7:0] din, input logic [9:0] seq,
                                input logic par, input logic sent_first);
        for (int c = 0; c < FRAME_CYC; c++) begin
            int   k;
            logic e;
            k = c / CPB;
            if (k == FRAME_BITS - 1)     e = seq[0];
            else if (PAR_EN && k == 9)   e = par;
            else                         e = seq[4'(9 - k)];
            check1($sformatf("tx %02h bit %0d cyc %0d", din, k, c % CPB), tx, e);
            check1($sformatf("is_transmitting %02h cyc %0d", din, c), is_transmitting, 1'b1);
            check1($sformatf("sent %02h cyc %0d", din, c), sent, (c == 0) ? sent_first : 1'b0);
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic [9:0] seq;
        logic       par;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n, s0;
        bit   line_ok;
        logic exp_rdy;

        vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
        vecs[1] = '{8'h07, 10'b0111000001, 1'b1};
        vecs[2] = '{8'h03, 10'b0110000001, 1'b0};
        vecs[3] = '{8'h3C, 10'b0001111001, 1'b0};
        vecs[4] = '{8'h80, 10'b0000000011, 1'b1};

        reset    = 1'b1;
        tx_start = 1'b0;
        tx_byte  = '0;
        repeat (3) @(negedge clk);
        check1("reset tx", tx, 1'b1);
        check1("reset ready", ready, 1'b1);
        check1("reset is_transmitting", is_transmitting, 1'b0);
        check1("reset sent", sent, 1'b0);
        check1("reset overflow", overflow, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single frames from idle.
        for (int v = 0; v < 5; v++) begin
            wait_idle(200);
            @(negedge clk);
            push(vecs[v].din);
            check1("latency tx still idle", tx, 1'b1);
            check1("latency not transmitting", is_transmitting, 1'b0);
            @(negedge clk);
            expect_frame(vecs[v].din, vecs[v].seq, vecs[v].par, 1'b0);
            check1("sent after frame", sent, 1'b1);
            check1("idle after frame", is_transmitting, 1'b0);
            check1("tx idle after frame", tx, 1'b1);
            @(negedge clk);
            check1("sent single cycle", sent, 1'b0);
        end

        // Back-to-back frames with no idle gap.
        wait_idle(200);
        @(negedge clk);
        push(8'h00);
        push(8'hFF);
        expect_frame(8'h00, 10'b0000000001, 1'b0, 1'b0);
        expect_frame(8'hFF, 10'b0111111111, 1'b0, 1'b1);
        check1("b2b second sent", sent, 1'b1);
        check1("b2b idle after", is_transmitting, 1'b0);

        // Overflow: six pushes, the sixth lands on a full FIFO.
        wait_idle(200);
        @(negedge clk);
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            exp_rdy = (i < 5);
            check1($sformatf("ready before push %0d", i), ready, exp_rdy);
            if (i == 5) check1("overflow before drop", overflow, 1'b0);
            push(8'(i + 1));
        end
        check1("overflow set", overflow, 1'b1);
        check1("ready low when full", ready, 1'b0);
        repeat (FRAME_CYC - 5) @(negedge clk);
        check1("ready low until first frame ends", ready, 1'b0);
        @(negedge clk);
        check1("ready after first pop of new data", ready, 1'b1);
        n = 0;
        while ((rx_q.size() < 5 || is_transmitting) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check8("overflow frame count", 8'(rx_q.size()), 8'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) check8($sformatf("overflow byte %0d", i), rx_q[i], 8'(i + 1));
        end
        check1("overflow sticky", overflow, 1'b1);

        // Reset during data bit 3 of 0x3C with two bytes queued behind it.
        @(negedge clk);
        rx_q.delete();
        push(8'h3C);
        push(8'h11);
        push(8'h22);
        repeat (16) @(negedge clk);
        check1("mid-frame before reset", is_transmitting, 1'b1);
        s0 = sent_cnt;
        #2 reset = 1'b1;
        #1;
        check1("reset mid tx", tx, 1'b1);
        check1("reset mid is_transmitting", is_transmitting, 1'b0);
        check1("reset mid sent", sent, 1'b0);
        check1("reset mid overflow", overflow, 1'b0);
        check1("reset mid ready", ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        line_ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || is_transmitting !== 1'b0) line_ok = 1'b0;
        end
        check1("line quiet after reset", line_ok, 1'b1);
        check8("sent pulses across reset", 8'(sent_cnt - s0), 8'd0);
        check8("frames after reset", 8'(rx_q.size()), 8'd0);
        push(8'h5A);
        @(negedge clk);
        wait_idle(200);
        @(negedge clk);
        check8("frames after new push", 8'(rx_q.size()), 8'd1);
        if (rx_q.size() > 0) check8("byte after reset", rx_q[0], 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
